// File: rtl/ex_unit_pkg.sv
// Shared opcode, operand-select and multiply/divide FSM definitions for the
// RV32IM execute stage.
package ex_unit_pkg;

  typedef enum logic [4:0] {
    ALU_NOP    = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_SLL    = 5'd3,
    ALU_SRL    = 5'd4,
    ALU_SRA    = 5'd5,
    ALU_XOR    = 5'd6,
    ALU_OR     = 5'd7,
    ALU_AND    = 5'd8,
    ALU_SLT    = 5'd9,
    ALU_SLTU   = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  localparam logic ALU_SRC_IMM = 1'b0;
  localparam logic ALU_SRC_RS2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per
// cycle on operand magnitudes, with the signs applied once the loop finishes.
module ex_muldiv
  import ex_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic            start_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic [XLEN-1:0] result_o,
  output logic            stallReq_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  muldiv_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic isDiv_q, isDiv_d, selHigh_q, selHigh_d, selRem_q, selRem_d;
  logic negQ_q, negQ_d, negR_q, negR_d, divZero_q, divZero_d;

  logic signA, signB, negA, negB, opDiv, opHigh, opRem, accept;
  logic [XLEN-1:0] absA, absB, quotient, remainder;
  logic [XLEN:0] mulSum, divTrial;
  logic [2*XLEN-1:0] product;

  assign accept = (state_q == IDLE) && start_i && !flush_i;

  always_comb begin : decode
    signA  = 1'b0;
    signB  = 1'b0;
    opDiv  = 1'b0;
    opHigh = 1'b0;
    opRem  = 1'b0;
    case (op_i)
      OP_W'(ALU_MUL):    begin signA = 1'b1; signB = 1'b1; end
      OP_W'(ALU_MULH):   begin signA = 1'b1; signB = 1'b1; opHigh = 1'b1; end
      OP_W'(ALU_MULHSU): begin signA = 1'b1; opHigh = 1'b1; end
      OP_W'(ALU_MULHU):  opHigh = 1'b1;
      OP_W'(ALU_DIV):    begin signA = 1'b1; signB = 1'b1; opDiv = 1'b1; end
      OP_W'(ALU_DIVU):   opDiv = 1'b1;
      OP_W'(ALU_REM):    begin signA = 1'b1; signB = 1'b1; opDiv = 1'b1; opRem = 1'b1; end
      OP_W'(ALU_REMU):   begin opDiv = 1'b1; opRem = 1'b1; end
      default: ;
    endcase
    negA = signA && op1_i[XLEN-1];
    negB = signB && op2_i[XLEN-1];
    absA = negA ? -op1_i : op1_i;
    absB = negB ? -op2_i : op2_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : nextState
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = CALC;
        CALC:    if (cnt_q == LAST_STEP) state_d = DONE;
        DONE:    if (!hold_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Multiply keeps {hi,lo} as partial product / remaining multiplier bits;
  // divide keeps hi as the partial remainder and lo as dividend/quotient bits.
  always_comb begin : datapath
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    isDiv_d   = isDiv_q;
    selHigh_d = selHigh_q;
    selRem_d  = selRem_q;
    negQ_d    = negQ_q;
    negR_d    = negR_q;
    divZero_d = divZero_q;
    mulSum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    divTrial  = {hi_q, lo_q[XLEN-1]} - {1'b0, m_q};
    if (accept) begin
      hi_d      = '0;
      lo_d      = opDiv ? absA : absB;
      m_d       = opDiv ? absB : absA;
      cnt_d     = '0;
      isDiv_d   = opDiv;
      selHigh_d = opHigh;
      selRem_d  = opRem;
      negQ_d    = negA ^ negB;
      negR_d    = negA;
      divZero_d = (op2_i == '0);
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (isDiv_q) begin
        if (!divTrial[XLEN]) begin
          hi_d = divTrial[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {mulSum, lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      isDiv_q   <= 1'b0;
      selHigh_q <= 1'b0;
      selRem_q  <= 1'b0;
      negQ_q    <= 1'b0;
      negR_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      isDiv_q   <= isDiv_d;
      selHigh_q <= selHigh_d;
      selRem_q  <= selRem_d;
      negQ_q    <= negQ_d;
      negR_q    <= negR_d;
      divZero_q <= divZero_d;
    end
  end

  // A zero divisor leaves the quotient all ones regardless of operand signs.
  always_comb begin : signFix
    product   = negQ_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quotient  = divZero_q ? '1 : (negQ_q ? -lo_q : lo_q);
    remainder = negR_q ? -hi_q : hi_q;
  end

  always_comb begin : fsmOutputs
    stallReq_o = 1'b0;
    busy_o     = (state_q != IDLE);
    result_o   = '0;
    case (state_q)
      IDLE: stallReq_o = start_i && !flush_i;
      CALC: stallReq_o = !flush_i;
      DONE: begin
        if (isDiv_q) result_o = selRem_q ? remainder : quotient;
        else         result_o = selHigh_q ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_unit.sv
// RV32IM execute stage: operand forwarding, single-cycle integer ALU and the
// iterative multiply/divide unit behind a common result select.
module ex_unit
  import ex_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic              rs1_rd_en_i,
  input  logic              rs2_rd_en_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [OP_W-1:0]   alu_op_i,
  input  logic              alu_src_i,
  input  logic              exmem_wr_en_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_data_i,
  input  logic              memwb_wr_en_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic [XLEN-1:0]   alu_res_o,
  output logic [XLEN-1:0]   bypass_op2_o,
  output logic              stall_req_o,
  output logic              busy_o
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] fwd1, fwd2, op2, aluRes, mdResult;
  logic [SHW-1:0] shamt;
  logic mOp, mdStall, mdBusy;
  logic unusedBits;

  // rd_addr only travels alongside the instruction; the other stall bits belong
  // to stages this block does not control.
  assign unusedBits = ^{rd_addr_i, stall_i[5:4], stall_i[2:0]};

  // The younger producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
  always_comb begin : forward
    fwd1 = rs1_data_i;
    if (rs1_rd_en_i && rs1_addr_i != '0 && exmem_wr_en_i && exmem_rd_i == rs1_addr_i)
      fwd1 = exmem_data_i;
    else if (rs1_rd_en_i && rs1_addr_i != '0 && memwb_wr_en_i && memwb_rd_i == rs1_addr_i)
      fwd1 = memwb_data_i;
    fwd2 = rs2_data_i;
    if (rs2_rd_en_i && rs2_addr_i != '0 && exmem_wr_en_i && exmem_rd_i == rs2_addr_i)
      fwd2 = exmem_data_i;
    else if (rs2_rd_en_i && rs2_addr_i != '0 && memwb_wr_en_i && memwb_rd_i == rs2_addr_i)
      fwd2 = memwb_data_i;
  end

  always_comb begin : operandSelect
    case (alu_src_i)
      ALU_SRC_IMM: op2 = imm_i;
      default:     op2 = fwd2;
    endcase
    shamt = op2[SHW-1:0];
    mOp   = (alu_op_i >= OP_W'(ALU_MUL)) && (alu_op_i <= OP_W'(ALU_REMU));
  end

  always_comb begin : alu
    aluRes = '0;
    case (alu_op_i)
      OP_W'(ALU_ADD):  aluRes = fwd1 + op2;
      OP_W'(ALU_SUB):  aluRes = fwd1 - op2;
      OP_W'(ALU_SLL):  aluRes = fwd1 << shamt;
      OP_W'(ALU_SRL):  aluRes = fwd1 >> shamt;
      OP_W'(ALU_SRA):  aluRes = $signed(fwd1) >>> shamt;
      OP_W'(ALU_XOR):  aluRes = fwd1 ^ op2;
      OP_W'(ALU_OR):   aluRes = fwd1 | op2;
      OP_W'(ALU_AND):  aluRes = fwd1 & op2;
      OP_W'(ALU_SLT):  aluRes = {{(XLEN-1){1'b0}}, ($signed(fwd1) < $signed(op2))};
      OP_W'(ALU_SLTU): aluRes = {{(XLEN-1){1'b0}}, (fwd1 < op2)};
      default:         aluRes = '0;
    endcase
  end

  ex_muldiv #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_muldiv (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .hold_i     (stall_i[3]),
    .start_i    (mOp),
    .op_i       (alu_op_i),
    .op1_i      (fwd1),
    .op2_i      (fwd2),
    .result_o   (mdResult),
    .stallReq_o (mdStall),
    .busy_o     (mdBusy)
  );

  always_comb begin : outputs
    alu_res_o    = '0;
    bypass_op2_o = '0;
    stall_req_o  = 1'b0;
    busy_o       = 1'b0;
    if (rst_i) begin
      alu_res_o    = mOp ? mdResult : aluRes;
      bypass_op2_o = fwd2;
      stall_req_o  = mdStall;
      busy_o       = mdBusy;
    end
  end

endmodule
